// File: rtl/mult_share_pkg.sv
// mult_share_pkg: shared types and encodings for the multiplier-sharing scheduler.
package mult_share_pkg;

    // scheduler sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // shift-register control encodings driven on sr_sel
    localparam logic [1:0] SR_HOLD  = 2'd0;
    localparam logic [1:0] SR_LOAD  = 2'd1;
    localparam logic [1:0] SR_SHIFT = 2'd2;

    // bit positions inside each requester's 2-bit sel field
    localparam int unsigned SEL_SQUARE = 0;
    localparam int unsigned SEL_MULT   = 1;

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N_REQ level requests.
// The search starts at i_ptr and wraps; o_win is one-hot, o_id its index.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDW   = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [IDW-1:0]   o_id,
    output logic             o_any
);

    logic [IDW-1:0] w_idx;

    // first asserted request at or after i_ptr, modulo N_REQ
    always_comb begin
        o_win = '0;
        o_id  = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = IDW'((k + 32'(i_ptr)) % N_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_win[w_idx] = 1'b1;
                o_id         = w_idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: sequences one shared shift-and-add multiplier datapath
// between N_REQ requesters. Round-robin grant, operands latched at grant,
// bit counter drives the SHIFT phase, done pulses tagged with the served id.
// Optional macro MULT_EARLY_TERM_EN: leave SHIFT as soon as the remaining
// multiplier bits are all zero (minimum one SHIFT cycle).
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter  int unsigned W     = 8,
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   sel,
    input  logic [W*N_REQ-1:0]   a_in,
    input  logic [W*N_REQ-1:0]   b_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [W-1:0]         sr_din,
    output logic [1:0]           sr_sel,
    output logic                 acc_ld,
    output logic                 acc_clr,
    output logic                 done,
    output logic [IDW-1:0]       done_id
);

    localparam int unsigned CW = $clog2(W) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   r_ptr;
    logic [N_REQ-1:0] r_onehot;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_mplier;
    logic [CW-1:0]    r_bit_cnt;

    logic [N_REQ-1:0] w_win;
    logic [IDW-1:0]   w_win_id;
    logic             w_any;
    logic [1:0]       w_win_sel;
    logic [W-1:0]     w_win_a;
    logic [W-1:0]     w_win_b;
    logic             w_last_shift;
    logic [IDW-1:0]   w_ptr_nxt;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_id  (w_win_id),
        .o_any (w_any)
    );

    // route the winning requester's mode and operands
    always_comb begin
        w_win_sel = '0;
        w_win_a   = '0;
        w_win_b   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (w_win[j]) begin
                w_win_sel = sel[j*2 +: 2];
                w_win_a   = a_in[j*W +: W];
                w_win_b   = b_in[j*W +: W];
            end
        end
    end

    // end-of-SHIFT detection and round-robin pointer advance
    always_comb begin
`ifdef MULT_EARLY_TERM_EN
        w_last_shift = (r_bit_cnt == CW'(W - 1)) || ((r_mplier >> 1) == '0);
`else
        w_last_shift = (r_bit_cnt == CW'(W - 1));
`endif
        w_ptr_nxt = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + IDW'(1);
    end

    // state register plus operand, counter and pointer latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_ptr     <= '0;
            r_onehot  <= '0;
            r_a       <= '0;
            r_mplier  <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id     <= w_win_id;
                        r_onehot <= w_win;
                        r_a      <= w_win_a;
                        r_mplier <= w_win_sel[SEL_SQUARE] ? w_win_a : w_win_b;
                    end
                end
                LOAD: begin
                    r_bit_cnt <= '0;
                end
                SHIFT: begin
                    r_mplier  <= r_mplier >> 1;
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
                DONE: begin
                    r_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    // next state and Moore output decode
    always_comb begin
        w_state_nxt = r_state;
        gnt         = '0;
        sr_din      = '0;
        sr_sel      = SR_HOLD;
        acc_ld      = 1'b0;
        acc_clr     = 1'b0;
        done        = 1'b0;
        done_id     = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_win_sel[SEL_MULT] ? LOAD : DONE;
                end
            end
            LOAD: begin
                gnt         = r_onehot;
                sr_din      = r_a;
                sr_sel      = SR_LOAD;
                acc_clr     = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                gnt    = r_onehot;
                sr_din = r_a;
                sr_sel = SR_SHIFT;
                acc_ld = r_mplier[0];
                if (w_last_shift) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                gnt         = r_onehot;
                sr_din      = r_a;
                done        = 1'b1;
                done_id     = r_id;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: transaction-level reference model with per-cycle
// comparison, a bench-side shift/accumulate datapath to form products,
// directed cases with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_mult_share_sched;

    localparam int unsigned W     = 8;
    localparam int unsigned N_REQ = 2;
    localparam int unsigned IDW   = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_REQ-1:0]     req;
    logic [2*N_REQ-1:0]   sel;
    logic [W*N_REQ-1:0]   a_in;
    logic [W*N_REQ-1:0]   b_in;
    logic [N_REQ-1:0]     gnt;
    logic [W-1:0]         sr_din;
    logic [1:0]           sr_sel;
    logic                 acc_ld;
    logic                 acc_clr;
    logic                 done;
    logic [IDW-1:0]       done_id;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mult_share_sched #(
        .W     (W),
        .N_REQ (N_REQ)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .sel     (sel),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .sr_din  (sr_din),
        .sr_sel  (sr_sel),
        .acc_ld  (acc_ld),
        .acc_clr (acc_clr),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // number of SHIFT cycles a multiplier value costs
    function automatic int shifts_for(input logic [W-1:0] m);
        int s;
`ifdef MULT_EARLY_TERM_EN
        s = 1;
        for (int i = 0; i < int'(W); i++) if (m[i]) s = i + 1;
`else
        s = int'(W);
`endif
        return s;
    endfunction

    // bench-side datapath: 2W shift register and accumulator
    logic [2*W-1:0] f_sr;
    logic [2*W-1:0] f_acc;

    // reference model: one operation is a timeline of k = 1..m_last cycles
    bit             m_busy = 0;
    int             m_k    = 0;
    int             m_last = 0;
    bit             m_mul  = 0;
    int             m_id   = 0;
    int             m_ptr  = 0;
    logic [W-1:0]   m_a    = '0;
    logic [W-1:0]   m_mpl  = '0;

    logic [N_REQ-1:0] e_gnt;
    logic [W-1:0]     e_din;
    logic [1:0]       e_ssel;
    logic             e_ld, e_clr, e_done;

    always @(negedge clk) begin
        e_gnt = '0; e_din = '0; e_ssel = 2'd0; e_ld = 1'b0; e_clr = 1'b0; e_done = 1'b0;
        if (!reset && m_busy) begin
            e_gnt[m_id] = 1'b1;
            e_din       = m_a;
            if (m_k == m_last) e_done = 1'b1;
            else if (m_k == 1) begin e_ssel = 2'd1; e_clr = 1'b1; end
            else begin e_ssel = 2'd2; e_ld = m_mpl[m_k-2]; end
        end
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("sr_din", 64'(sr_din), 64'(e_din));
        chk("sr_sel", 64'(sr_sel), 64'(e_ssel));
        chk("acc_ld", 64'(acc_ld), 64'(e_ld));
        chk("acc_clr", 64'(acc_clr), 64'(e_clr));
        chk("done", 64'(done), 64'(e_done));
        if (e_done) chk("done_id", 64'(done_id), 64'(m_id));
        if (e_done && m_mul) chk("product", 64'(f_acc), 64'(m_a) * 64'(m_mpl));

        if (acc_clr) f_acc <= '0;
        else if (acc_ld) f_acc <= f_acc + f_sr;
        if (sr_sel == 2'd1) f_sr <= {{W{1'b0}}, sr_din};
        else if (sr_sel == 2'd2) f_sr <= f_sr << 1;

        if (reset) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                int idx;
                idx = (m_ptr + i) % int'(N_REQ);
                if (!m_busy && req[idx]) begin
                    m_busy = 1;
                    m_k    = 1;
                    m_id   = idx;
                    m_mul  = sel[idx*2+1];
                    m_a    = a_in[idx*W +: W];
                    m_mpl  = sel[idx*2] ? a_in[idx*W +: W] : b_in[idx*W +: W];
                    m_last = m_mul ? shifts_for(m_mpl) + 2 : 1;
                end
            end
        end else if (m_k == m_last) begin
            m_busy = 0;
            m_ptr  = (m_id + 1) % int'(N_REQ);
        end else begin
            m_k++;
        end
    end

    // one request from idle to done; called at posedge+1 with the DUT idle
    task automatic run_one(input int id, input logic [1:0] s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int exp_lat, input int exp_acc,
                           input logic [W-1:0] exp_pat, input bit drop_mid);
        int t0, nsh, nclr;
        bit seen;
        logic [W-1:0] pat;
        req[id] = 1'b1;
        sel[id*2 +: 2] = s;
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
        t0 = cyc; seen = 0; nsh = 0; nclr = 0; pat = '0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (sr_sel == 2'd2) begin
                if (nsh < int'(W)) pat[nsh] = acc_ld;
                nsh++;
            end
            if (acc_clr) nclr++;
            if (done) begin
                seen = 1;
                chk("latency", 64'(cyc - t0), 64'(exp_lat));
                chk("run_done_id", 64'(done_id), 64'(id));
                if (exp_acc >= 0) chk("run_acc", 64'(f_acc), 64'(exp_acc));
                chk("acc_ld_pattern", 64'(pat), 64'(exp_pat));
                chk("shift_cycles", 64'(nsh), 64'(s[1] ? exp_lat - 2 : 0));
                chk("acc_clr_cycles", 64'(nclr), 64'(s[1] ? 1 : 0));
            end else begin
                @(posedge clk); #1;
                if (drop_mid && n == 1) begin
                    req[id] = 1'b0;
                    sel[id*2 +: 2] = ~s;
                    a_in[id*W +: W] = W'($urandom);
                    b_in[id*W +: W] = W'($urandom);
                end
            end
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    initial begin
        int ids[3];
        int nd, t0;
        bit dn;
        int did;
        reset = 1'b1; req = '0; sel = '0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_sr_sel", 64'(sr_sel), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_acc_clr", 64'(acc_clr), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef MULT_EARLY_TERM_EN
        run_one(0, 2'b10, 8'd13,  8'd11, 6,  143,  8'b00001011, 0);
        run_one(0, 2'b11, 8'd5,   8'd99, 5,  25,   8'b00000101, 0);
        run_one(1, 2'b00, 8'd40,  8'd2,  1,  -1,   8'b00000000, 0);
        run_one(1, 2'b10, 8'd7,   8'd3,  4,  21,   8'b00000011, 0);
        run_one(0, 2'b10, 8'd9,   8'd0,  3,  0,    8'b00000000, 0);
        run_one(0, 2'b10, 8'd100, 8'd37, 8,  3700, 8'b00100101, 1);
`else
        run_one(0, 2'b10, 8'd13,  8'd11, 10, 143,  8'b00001011, 0);
        run_one(0, 2'b11, 8'd5,   8'd99, 10, 25,   8'b00000101, 0);
        run_one(1, 2'b00, 8'd40,  8'd2,  1,  -1,   8'b00000000, 0);
        run_one(1, 2'b10, 8'd7,   8'd3,  10, 21,   8'b00000011, 0);
        run_one(0, 2'b10, 8'd9,   8'd0,  10, 0,    8'b00000000, 0);
        run_one(0, 2'b10, 8'd100, 8'd37, 10, 3700, 8'b00100101, 1);
`endif

        // reset in the 4th SHIFT cycle of a multiply on requester 1
        req[1] = 1'b1; sel[3:2] = 2'b10; a_in[15:8] = 8'd200; b_in[15:8] = 8'd255;
        t0 = cyc;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_shift", 64'(sr_sel), 64'(2));
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 64'(gnt), 64'(0));
        chk("mid_rst_sr_sel", 64'(sr_sel), 64'(0));
        chk("mid_rst_acc_ld", 64'(acc_ld), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0; req = '0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_done", 64'(done), 64'(0));
        end
        @(posedge clk); #1;

        // simultaneous held requests: order after reset must be 0,1,0
        req = 2'b11; sel = 4'b1010;
        a_in = {8'd3, 8'd4}; b_in = {8'd5, 8'd6};
        nd = 0;
        for (int n = 0; n < 100 && nd < 3; n++) begin
            @(negedge clk);
            if (done) begin ids[nd] = int'(done_id); nd++; end
            @(posedge clk); #1;
        end
        req = '0;
        chk("rr_count", 64'(nd), 64'(3));
        chk("rr_first", 64'(ids[0]), 64'(0));
        chk("rr_second", 64'(ids[1]), 64'(1));
        chk("rr_third", 64'(ids[2]), 64'(0));
        repeat (3) @(posedge clk);
        #1;

        // randomized traffic; requests held until their own done
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            dn = done; did = int'(done_id);
            @(posedge clk); #1;
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req[i]) begin
                    if (dn && did == i && $urandom_range(3) != 0) req[i] = 1'b0;
                    if ($urandom_range(7) == 0) a_in[i*W +: W] = W'($urandom);
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    sel[i*2 +: 2] = 2'($urandom);
                    a_in[i*W +: W] = W'($urandom);
                    b_in[i*W +: W] = ($urandom_range(5) == 0) ? '0 : W'($urandom);
                end
            end
        end
        req = '0;
        repeat (30) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Scheduler sharing one shift-and-add multiplier datapath (shift register plus accumulator) between N_REQ requesters in the calculator.
- Arbitrates round-robin and latches the winner's operands and mode.
- Sequences the datapath with a bit counter instead of per-bit states.
- Pulses done, tagged with the served requester id, so that requester can capture the accumulator result.

Parameters:
W, 8, operand width; bit counter sized $clog2(W)+1
N_REQ, 2, number of requesters; id width IDW = max(1,$clog2(N_REQ))

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
req  in  N_REQ  level request per requester; held until own done
sel  in  2*N_REQ  per-requester mode: sel[1]=1 multiply-class, sel[0]=1 square (A*A), sel[1]=0 add/sub (no datapath sequencing)
a_in  in  W*N_REQ  per-requester operand A
b_in  in  W*N_REQ  per-requester operand B
gnt  out  N_REQ  one-hot grant, high from LOAD (or DONE for add/sub) through DONE
sr_din  out  W  latched A, presented to the shift register load port
sr_sel  out  2  0 hold, 1 load sr_din, 2 shift left
acc_ld  out  1  accumulator adds the current (pre-shift) shift-register value
acc_clr  out  1  clear accumulator
done  out  1  one-cycle pulse: result valid for the granted requester
done_id  out  IDW  id of the requester served; valid when done=1

Behaviour:
- Reset (async): state IDLE, rr_ptr=0, gnt/sr_sel/acc_ld/acc_clr/done/done_id/sr_din all 0, mplier=0, bit_cnt=0.
- Outputs are Moore-decoded from registered state and latched registers. No combinational path from req to outputs.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Outputs 0.
  - If any req: winner is the first asserted req searching from rr_ptr upward with wrap.
  - Latch id, A into sr_din, mplier = sel[0] ? A : B (of the winner).
  - If winner sel[1]=1 -> LOAD; else -> DONE.
- LOAD: sr_sel=1, acc_clr=1, gnt[id]=1; bit_cnt=0; -> SHIFT.
- SHIFT:
  - sr_sel=2, acc_ld=mplier[0], gnt[id]=1.
  - Each cycle: mplier >>= 1, bit_cnt++.
  - After W SHIFT cycles -> DONE.
- DONE:
  - done=1, done_id=id, gnt[id]=1.
  - rr_ptr = (id+1) mod N_REQ; -> IDLE.
- Latency, counted from the IDLE cycle with req high as cycle 0:
  - Multiply: LOAD cycle 1, SHIFT cycles 2..W+1, done at cycle W+2.
  - Add/sub: done at cycle 1.
- Minimum gap between grants: one IDLE cycle after every DONE.
- Boundaries:
  - Operands are sampled only at grant. Later changes to a_in/b_in/sel are ignored.
  - req dropped mid-operation: operation still completes and done still pulses; requester may ignore it.
  - Simultaneous requests: round-robin order. A requester never waits more than N_REQ-1 operations.
  - A requester still high after its own done is granted again only if no other request is pending at rr_ptr order.
  - mplier=0: all acc_ld=0, result 0, full W-cycle latency unless early termination is enabled.
  - reset mid-SHIFT: immediate return to IDLE, all outputs 0, no done.
  - Product width is the datapath's concern; this block only sequences.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined: in SHIFT, if remaining mplier (after the current bit) is 0, go to DONE after this cycle. Multiply latency becomes LOAD + (index of highest set multiplier bit + 1) SHIFT cycles + DONE, with a minimum of one SHIFT cycle.
- Undefined: fixed W SHIFT cycles.

Decomposition:
- Package mult_share_pkg: state enum (IDLE, LOAD, SHIFT, DONE), sr_sel encodings SR_HOLD=0, SR_LOAD=1, SR_SHIFT=2, and the sel bit index constants.
- One sub-module: rr_arbiter (req vector plus rr_ptr in; one-hot winner and id out; combinational).

Test Plan:
- Mult A=13, B=11, sel=2'b10, req0 only -> LOAD at cycle 1; acc_ld over SHIFT = 1,1,0,1,0,0,0,0; done=1, done_id=0 at cycle 10; datapath accumulator=143.
- Square A=5, B=99, sel=2'b11 -> mplier=5; acc_ld = 1,0,1,0,0,0,0,0; result 25.
- req0 and req1 rise together after reset, both held -> req0 served first, then req1, then req0 again; gnt never has two bits set.
- Add/sub sel=2'b00 on req1 -> gnt[1] and done with done_id=1 at cycle 1; sr_sel, acc_ld and acc_clr remain 0.
- reset asserted in the 4th SHIFT cycle -> outputs 0 in the same cycle, no done pulse; a new request afterwards restarts cleanly with rr_ptr=0.
- With MULT_EARLY_TERM_EN, A=7, B=3 -> 2 SHIFT cycles, done at cycle 4, result 21. Without the macro, done at cycle 10.
